// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader.
//   - default operand / opcode width
//   - ALU opcode encodings (ADD..NOR) as seen on o_OP
//   - loader FSM state encodings, also driven onto the status LEDs
// Build option: ALU_LOADER_DEBOUNCE_EN (see alu_operand_loader_btn_conditioner).
package alu_operand_loader_pkg;

  localparam int unsigned N_BITS_DEFAULT = 6;

  // ALU opcodes, MIPS-style funct encodings.
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Encoding 2'd3 is unused and recovers to S_WAIT_A.
  typedef enum logic [1:0] {
    S_WAIT_A  = 2'd0,
    S_WAIT_B  = 2'd1,
    S_WAIT_OP = 2'd2
  } state_e;

  // True when op is one of the opcodes the ALU implements.
  function automatic logic is_alu_opcode(logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
  endfunction

endpackage

// File: rtl/alu_operand_loader_btn_conditioner.sv
// Raw board button -> single-cycle press pulse.
//   2-FF synchronizer -> optional debounce -> rising-edge detect (registered).
// Build option: ALU_LOADER_DEBOUNCE_EN
//   defined   : a level is accepted only after DEBOUNCE_CYCLES consecutive cycles of the
//               synced input differing from the current debounced level.
//   undefined : debounced level is the synced level; DEBOUNCE_CYCLES has no effect.
// Ports:
//   clock    in  system clock, posedge
//   reset    in  asynchronous active-low reset
//   i_btn    in  raw, asynchronous button level
//   o_press  out one-cycle pulse per accepted press (holding the button gives one pulse)
module alu_operand_loader_btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  logic [1:0] sync_q;
  logic       level;
  logic       level_prev_q;
  logic       press_q;

  // Zero is not a legal debounce length; such a build has no valid behaviour.
  if (DEBOUNCE_CYCLES == 0) begin : g_illegal_debounce_cycles
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_btn};
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            level_q;

  // The counter only runs while the synced input disagrees with the debounced level, so any
  // glitch shorter than DEBOUNCE_CYCLES restarts it from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      level_q <= ~level_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = level_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      level_prev_q <= level;
      press_q      <= level & ~level_prev_q;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Upstream stage of the ALU: captures A, B and OP from the shared switch bank, one button
// press each, strictly in the order A -> B -> OP, then presents all three together.
// Build option: ALU_LOADER_DEBOUNCE_EN enables button debouncing (DEBOUNCE_CYCLES).
// Ports:
//   clock      in   system clock, posedge
//   reset      in   asynchronous active-low reset
//   i_sw       in   switch bank, quasi-static, sampled in the cycle of a press
//   i_btn_a    in   raw button: load A
//   i_btn_b    in   raw button: load B
//   i_btn_op   in   raw button: load OP
//   o_A/o_B    out  operands to the ALU
//   o_OP       out  opcode to the ALU
//   o_valid    out  one-cycle pulse: o_A/o_B/o_OP just updated together
//   o_seq_err  out  one-cycle pulse: an out-of-order press was ignored
//   o_state    out  FSM state for status LEDs (0 wait A, 1 wait B, 2 wait OP)
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int unsigned N_BITS          = N_BITS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_BITS-1:0] o_OP,
  output logic              o_valid,
  output logic              o_seq_err,
  output logic [1:0]        o_state
);

  logic press_a;
  logic press_b;
  logic press_op;

  alu_operand_loader_btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_a (
    .clock  (clock),
    .reset  (reset),
    .i_btn  (i_btn_a),
    .o_press(press_a)
  );

  alu_operand_loader_btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_b (
    .clock  (clock),
    .reset  (reset),
    .i_btn  (i_btn_b),
    .o_press(press_b)
  );

  alu_operand_loader_btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_op (
    .clock  (clock),
    .reset  (reset),
    .i_btn  (i_btn_op),
    .o_press(press_op)
  );

  state_e            state_q;
  logic [N_BITS-1:0] stage_a_q;
  logic [N_BITS-1:0] stage_b_q;

  // A and B are staged privately; the ALU-facing registers are only written on the OP press,
  // so the ALU never sees a partially loaded operand set. Any press other than the one the
  // current state expects raises o_seq_err, even when the expected press arrives alongside it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_WAIT_A;
      stage_a_q <= '0;
      stage_b_q <= '0;
      o_A       <= '0;
      o_B       <= '0;
      o_OP      <= '0;
      o_valid   <= 1'b0;
      o_seq_err <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_seq_err <= 1'b0;
      case (state_q)
        S_WAIT_A: begin
          if (press_a) begin
            stage_a_q <= i_sw;
            state_q   <= S_WAIT_B;
          end
          o_seq_err <= press_b | press_op;
        end
        S_WAIT_B: begin
          if (press_b) begin
            stage_b_q <= i_sw;
            state_q   <= S_WAIT_OP;
          end
          o_seq_err <= press_a | press_op;
        end
        S_WAIT_OP: begin
          if (press_op) begin
            o_A     <= stage_a_q;
            o_B     <= stage_b_q;
            o_OP    <= i_sw;
            o_valid <= 1'b1;
            state_q <= S_WAIT_A;
          end
          o_seq_err <= press_a | press_b;
        end
        default: state_q <= S_WAIT_A;
      endcase
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios plus randomized button/switch traffic,
// scored against a press-level model of the A -> B -> OP loading protocol.
module tb_alu_operand_loader;

  localparam int unsigned N_BITS = 6;
  localparam int unsigned DEB    = 4;
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int unsigned LAT    = 2 + DEB + 1 + 1;
  localparam bit          DEB_EN = 1'b1;
`else
  localparam int unsigned LAT    = 2 + 1 + 1;
  localparam bit          DEB_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N_BITS-1:0] i_sw = '0;
  logic              i_btn_a = 1'b0;
  logic              i_btn_b = 1'b0;
  logic              i_btn_op = 1'b0;
  logic [N_BITS-1:0] o_A;
  logic [N_BITS-1:0] o_B;
  logic [N_BITS-1:0] o_OP;
  logic              o_valid;
  logic              o_seq_err;
  logic [1:0]        o_state;

  always #5 clock = ~clock;

  alu_operand_loader #(
    .N_BITS         (N_BITS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_sw     (i_sw),
    .i_btn_a  (i_btn_a),
    .i_btn_b  (i_btn_b),
    .i_btn_op (i_btn_op),
    .o_A      (o_A),
    .o_B      (o_B),
    .o_OP     (o_OP),
    .o_valid  (o_valid),
    .o_seq_err(o_seq_err),
    .o_state  (o_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: pulse counts, cycle of the last o_valid, and any output change that
  // happens without o_valid (a torn update).
  int                cyc = 0;
  int                valid_cnt = 0;
  int                err_cnt = 0;
  int                torn_cnt = 0;
  int                valid_cyc = -1;
  logic [N_BITS-1:0] prev_a = '0;
  logic [N_BITS-1:0] prev_b = '0;
  logic [N_BITS-1:0] prev_op = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      if (o_valid) begin
        valid_cnt++;
        valid_cyc = cyc;
      end
      if (o_seq_err) err_cnt++;
      if (!o_valid && ({o_A, o_B, o_OP} != {prev_a, prev_b, prev_op})) torn_cnt++;
    end
    prev_a  = o_A;
    prev_b  = o_B;
    prev_op = o_OP;
  end

  // Reference model at the level of accepted presses. Order index 0=A, 1=B, 2=OP; the
  // press mask uses the same bit positions.
  int                m_state;
  logic [N_BITS-1:0] m_stage[2];
  logic [N_BITS-1:0] m_out[3];

  task automatic model_reset();
    m_state = 0;
    m_stage[0] = '0;
    m_stage[1] = '0;
    for (int i = 0; i < 3; i++) m_out[i] = '0;
  endtask

  task automatic model_press(input logic [2:0] mask, input logic [N_BITS-1:0] sw,
                             output int exp_valid, output int exp_err);
    logic [2:0] expected_bit;
    expected_bit = 3'b001 << m_state;
    exp_valid = 0;
    exp_err   = ((mask & ~expected_bit) != 3'b000) ? 1 : 0;
    if (mask[m_state]) begin
      if (m_state < 2) begin
        m_stage[m_state] = sw;
      end else begin
        m_out[0] = m_stage[0];
        m_out[1] = m_stage[1];
        m_out[2] = sw;
        exp_valid = 1;
      end
      m_state = (m_state + 1) % 3;
    end
  endtask

  // Hold the masked buttons high for 'hold' cycles, release, and wait for all effects.
  task automatic press(input logic [2:0] mask, input logic [N_BITS-1:0] sw, input int hold,
                       output int n_valid, output int n_err, output int lat);
    int v0;
    int e0;
    int c0;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(posedge clock);
    #1;
    i_sw = sw;
    c0 = cyc;
    {i_btn_op, i_btn_b, i_btn_a} = mask;
    repeat (hold) @(posedge clock);
    #1;
    {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
    repeat (DEB + 8) @(posedge clock);
    #1;
    n_valid = valid_cnt - v0;
    n_err   = err_cnt - e0;
    lat     = valid_cyc - c0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_state"}, 32'(o_state), 32'(m_state));
    check_eq({tag, "_oA"}, 32'(o_A), 32'(m_out[0]));
    check_eq({tag, "_oB"}, 32'(o_B), 32'(m_out[1]));
    check_eq({tag, "_oOP"}, 32'(o_OP), 32'(m_out[2]));
  endtask

  task automatic step(input string tag, input logic [2:0] mask, input logic [N_BITS-1:0] sw,
                      input int hold);
    int n_valid;
    int n_err;
    int lat;
    int e_valid;
    int e_err;
    press(mask, sw, hold, n_valid, n_err, lat);
    model_press(mask, sw, e_valid, e_err);
    check_eq({tag, "_valid"}, 32'(n_valid), 32'(e_valid));
    check_eq({tag, "_seqerr"}, 32'(n_err), 32'(e_err));
    check_outputs(tag);
    if (e_valid == 1) check_eq({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int         v0;
    int         e0;
    int         e_valid;
    int         e_err;
    logic [2:0] mask;

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_state", 32'(o_state), 32'd0);
    check_eq("rst_oA", 32'(o_A), 32'd0);
    check_eq("rst_oB", 32'(o_B), 32'd0);
    check_eq("rst_oOP", 32'(o_OP), 32'd0);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_seqerr", 32'(o_seq_err), 32'd0);
    reset = 1'b1;

    // In-order load.
    step("t1_a", 3'b001, 6'd5, DEB + 3);
    step("t1_b", 3'b010, 6'd3, DEB + 3);
    step("t1_op", 3'b100, 6'b100000, DEB + 3);

    // B pressed while waiting for A.
    step("t2_b_early", 3'b010, 6'd17, DEB + 3);

    // Bouncy A press: three short pulses, then a solid hold.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(posedge clock);
    #1;
    i_sw = 6'd42;
    for (int i = 0; i < 3; i++) begin
      i_btn_a = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      i_btn_a = 1'b0;
      repeat (2) @(posedge clock);
      #1;
    end
    i_btn_a = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    i_btn_a = 1'b0;
    repeat (DEB + 8) @(posedge clock);
    #1;
    model_press(3'b001, 6'd42, e_valid, e_err);
    // Without debounce every pulse is a press; the three extra A presses arrive in S_WAIT_B.
    if (!DEB_EN) e_err = e_err + 3;
    check_eq("t3_bounce_valid", 32'(valid_cnt - v0), 32'(e_valid));
    check_eq("t3_bounce_seqerr", 32'(err_cnt - e0), 32'(e_err));
    check_outputs("t3_bounce");

    // B and OP together while waiting for B, then finish the set.
    step("t4_b_op", 3'b110, 6'd7, DEB + 3);
    step("t4_op", 3'b100, 6'($urandom), DEB + 3);

    // Reset in the middle of a sequence discards staged A/B.
    step("t5_a", 3'b001, 6'd9, DEB + 3);
    step("t5_b", 3'b010, 6'd1, DEB + 3);
    apply_reset();
    #1;
    check_outputs("t5_after_rst");
    step("t5_a2", 3'b001, 6'd2, DEB + 3);
    step("t5_b2", 3'b010, 6'd2, DEB + 3);
    step("t5_op2", 3'b100, 6'($urandom), DEB + 3);

    // OP held for a long time gives a single load.
    step("t6_a", 3'b001, 6'($urandom), DEB + 3);
    step("t6_b", 3'b010, 6'($urandom), DEB + 3);
    step("t6_op_held", 3'b100, 6'($urandom), 50);

    // Random traffic: any button combination, random switches and hold lengths.
    for (int i = 0; i < 40; i++) begin
      mask = 3'($urandom_range(7, 1));
      step($sformatf("rnd%0d", i), mask, 6'($urandom), int'($urandom_range(DEB + 12, DEB + 2)));
    end

    check_eq("no_torn_update", 32'(torn_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
